polar_encoder: RTL and testbench
================================

POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 Parameter N, default 8, code length; power of two, 4..64.
REQ-002 Parameter K, default 4, info bits per frame; SHALL equal the number of zero bits in FROZEN_MASK.
REQ-003 Parameter FROZEN_MASK, default 8'b0001_0111, N bits; bit i = 1 means position i is frozen (value 0).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_bit is valid.
REQ-007 in_ready  output  1  encoder accepts an info bit this cycle.
REQ-008 in_bit  input  1  serial info bit, first bit first.
REQ-009 out_valid  output  1  out_bit is valid.
REQ-010 out_ready  input  1  downstream accepts out_bit.
REQ-011 out_bit  output  1  serial codeword bit x[0] first.
REQ-012 out_last  output  1  high with out_bit carrying x[N-1].

Function
REQ-013 States: LOAD, ENCODE, SEND; reset state LOAD.
REQ-014 N-bit register u; cleared to all-zero on reset and on every entry into LOAD.
REQ-015 LOAD: in_ready = 1; otherwise in_ready = 0.
REQ-016 An input transfer occurs on in_valid && in_ready.
REQ-017 The j-th accepted bit (j = 0..K-1) SHALL be written to u[p_j], where p_j is the j-th lowest index with FROZEN_MASK bit = 0.
REQ-018 Frozen positions SHALL remain 0.
REQ-019 LOAD -> ENCODE on the edge accepting the K-th bit.
REQ-020 in_valid low in LOAD: hold, no state change.
REQ-021 ENCODE: stage counter s runs 0..log2(N)-1, one stage per cycle.
REQ-022 In stage s, for every i with bit s of i = 0: u[i] <= u[i] ^ u[i + 2^s]; u[i + 2^s] unchanged.
REQ-023 Result: x = u * F^(tensor log2 N), natural order, no bit reversal, so x[j] = XOR of u[i] over all i where (i & j) == j.
REQ-024 ENCODE -> SEND after exactly log2(N) cycles.
REQ-025 Latency: first out_valid is the cycle log2(N)+1 after the clock edge that accepts the last info bit (4 cycles for N=8).
REQ-026 SEND: out_valid = 1, out_bit = x[cnt], cnt starting at 0; out_last = (cnt == N-1).
REQ-027 cnt advances on out_valid && out_ready.
REQ-028 out_ready low: out_bit and out_last held stable, no advance.
REQ-029 The transfer with out_last SHALL return the block to LOAD, clear u, and zero all counters; in_ready = 1 in the next cycle.
REQ-030 out_valid = 0 and out_last = 0 outside SEND.
REQ-031 in_valid is ignored outside LOAD; in_bit is not stored.
REQ-032 Counters SHALL be clog2(N)+1 bits wide with no wrap-around inside a frame.

Reset
REQ-033 rst_n low SHALL immediately, without a clock, force:
- state = LOAD
- u = 0, all counters = 0
- in_ready = 1
- out_valid = 0, out_bit = 0, out_last = 0
REQ-034 Reset asserted mid-LOAD, mid-ENCODE or mid-SEND SHALL discard the partial frame; after release, the first accepted bit is info bit 0 of a new frame.

Verification
REQ-035 Defaults, info bits 1,0,0,0, out_ready = 1 -> out_bit 1,1,1,1,0,0,0,0; out_last on the 8th bit; out_valid rises 4 cycles after the last input edge.
REQ-036 Defaults, info bits 1,1,1,1 -> out_bit 0,1,1,0,1,0,0,1.
REQ-037 Defaults, info 0,0,0,1 (u[7] = 1), out_ready toggling 1/0 each cycle -> all 8 bits = 1; bits held during stalls; exactly 8 transfers.
REQ-038 Back-to-back frames (1,0,0,0 then 1,1,1,1) with in_valid held high -> second codeword 0,1,1,0,1,0,0,1; no bits from the first frame carried over.
REQ-039 rst_n pulsed low during SEND after 3 bits -> out_valid drops at once; the next frame 1,0,0,0 yields 1,1,1,1,0,0,0,0.
REQ-040 in_valid high during ENCODE/SEND with random in_bit -> in_ready = 0 and the codeword is unaffected.

Source files
------------

// File: rtl/polar_encoder.sv
// rtl/polar_encoder.sv - serial-in / serial-out polar encoder (x = u * F^(tensor log2 N))
//
// Ports:
//   clk        single clock, rising-edge state updates
//   rst_n      asynchronous active-low reset
//   in_valid   in_bit is valid
//   in_ready   encoder accepts an info bit this cycle (LOAD only)
//   in_bit     serial info bit, first bit first
//   out_valid  out_bit is valid (SEND only)
//   out_ready  downstream accepts out_bit
//   out_bit    serial codeword bit, x[0] first
//   out_last   marks the bit carrying x[N-1]
module polar_encoder #(
    parameter int             N           = 8,
    parameter int             K           = 4,
    parameter logic [N-1:0]   FROZEN_MASK = 8'b0001_0111
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last
);

    localparam int LOG2N = $clog2(N);
    localparam int CW    = LOG2N + 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    u_q, u_d;
    // One counter serves all phases: info-bit index in LOAD, butterfly
    // stage in ENCODE, codeword bit index in SEND. It is zeroed on every
    // state change so each phase starts from 0.
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_bit_q, out_bit_d;
    logic            out_last_q, out_last_d;

    // Index of the j-th non-frozen position, lowest index first.
    function automatic logic [LOG2N-1:0] free_pos(input logic [CW-1:0] j);
        int seen;
        seen     = 0;
        free_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (!FROZEN_MASK[i]) begin
                if (seen == int'(j)) begin
                    free_pos = LOG2N'(i);
                end
                seen = seen + 1;
            end
        end
    endfunction

    // Positions i whose bit t is 0: the upper node of each stage-t butterfly.
    function automatic logic [N-1:0] upper_mask(input int t);
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (((i >> t) & 1) == 0);
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        u_d         = u_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;
        cnt_inc     = cnt_q + CW'(1);

        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    u_d[free_pos(cnt_q)] = in_bit;
                    if (cnt_q == CW'(K - 1)) begin
                        state_d    = ST_ENCODE;
                        cnt_d      = '0;
                        in_ready_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_ENCODE: begin
                // Stage t: u[i] ^= u[i + 2^t] for every upper node i, done
                // as one vector op by shifting the lower nodes down onto them.
                for (int t = 0; t < LOG2N; t++) begin
                    if (cnt_q == CW'(t)) begin
                        u_d = u_q ^ ((u_q >> (1 << t)) & upper_mask(t));
                    end
                end
                if (cnt_q == CW'(LOG2N - 1)) begin
                    state_d     = ST_SEND;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    // x[0] is taken from the final stage result being written now.
                    out_bit_d   = u_d[0];
                    out_last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_SEND: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = ST_LOAD;
                        u_d         = '0;
                        cnt_d       = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_bit_d   = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        cnt_d      = cnt_inc;
                        out_bit_d  = u_q[cnt_inc[LOG2N-1:0]];
                        out_last_d = (cnt_inc == CW'(N - 1));
                    end
                end
            end

            default: begin
                state_d     = ST_LOAD;
                u_d         = '0;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                out_bit_d   = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            u_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_polar_encoder.sv
// tb/tb_polar_encoder.sv - self-checking bench for polar_encoder against a subset-XOR reference
module tb_polar_encoder;

    localparam int           N     = 8;
    localparam int           K     = 4;
    localparam int           LOG2N = 3;
    localparam logic [N-1:0] MASK  = 8'b0001_0111;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic out_valid;
    logic out_ready;
    logic out_bit;
    logic out_last;

    int n_vec = 0;
    int n_err = 0;

    polar_encoder #(.N(N), .K(K), .FROZEN_MASK(MASK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // info[j] is the j-th transmitted info bit. Places it at the j-th free
    // position, then x[j] = XOR of u[i] over all supersets i of j.
    function automatic logic [N-1:0] ref_code(input logic [K-1:0] info);
        logic [N-1:0] u;
        int           j;
        logic         acc;
        u = '0;
        j = 0;
        for (int i = 0; i < N; i++) begin
            if (!MASK[i]) begin
                u[i] = info[j];
                j    = j + 1;
            end
        end
        for (int jj = 0; jj < N; jj++) begin
            acc = 1'b0;
            for (int i = 0; i < N; i++) begin
                if ((i & jj) == jj) acc = acc ^ u[i];
            end
            ref_code[jj] = acc;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge of the last bit.
    task automatic load_frame(input logic [K-1:0] info, input bit hold_valid);
        for (int j = 0; j < K; j++) begin
            in_valid = 1'b1;
            in_bit   = info[j];
            chk("in_ready_load", 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        if (!hold_valid) in_valid = 1'b0;
    endtask

    // mode 0: out_ready always 1; 1: toggles 1/0; 2: random.
    task automatic run_send(input logic [K-1:0] info, input int mode, input bit noise,
                            input int stop_after);
        logic [N-1:0] x;
        int           cyc;
        int           cnt;
        int           guard;
        bit           tog;
        logic         prev_bit;
        bit           stalled;
        x        = ref_code(info);
        cyc      = 1;
        cnt      = 0;
        guard    = 0;
        tog      = 1'b1;
        prev_bit = 1'b0;
        stalled  = 1'b0;
        while (!out_valid && cyc < 20) begin
            chk("in_ready_encode", 32'(in_ready), 32'd0);
            chk("out_last_idle", 32'(out_last), 32'd0);
            if (noise) in_bit = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(LOG2N + 1));
        while (cnt < stop_after && guard < 64) begin
            guard++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = tog; tog = !tog; end
                default: out_ready = 1'($urandom);
            endcase
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_bit", 32'(out_bit), 32'(x[cnt]));
            chk("out_last", 32'(out_last), 32'(cnt == N - 1));
            chk("in_ready_send", 32'(in_ready), 32'd0);
            if (stalled) chk("out_bit_held", 32'(out_bit), 32'(prev_bit));
            if (noise) begin
                in_valid = 1'b1;
                in_bit   = 1'($urandom);
            end
            prev_bit = out_bit;
            stalled  = !out_ready;
            @(posedge clk);
            @(negedge clk);
            if (out_ready) cnt++;
        end
        chk("transfers", 32'(cnt), 32'(stop_after));
        if (stop_after == N) begin
            chk("out_valid_after", 32'(out_valid), 32'd0);
            chk("out_last_after", 32'(out_last), 32'd0);
            chk("in_ready_after", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [K-1:0] info;
        int           mode;
        bit           noise;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bit", 32'(out_bit), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;

        // Idle LOAD: nothing moves while in_valid is low.
        repeat (3) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Info 1,0,0,0 -> 1,1,1,1,0,0,0,0
        load_frame(4'b0001, 1'b0);
        run_send(4'b0001, 0, 1'b0, N);

        // Info 1,1,1,1 -> 0,1,1,0,1,0,0,1
        load_frame(4'b1111, 1'b0);
        run_send(4'b1111, 0, 1'b0, N);

        // Info 0,0,0,1 with out_ready toggling -> all ones, held on stalls
        load_frame(4'b1000, 1'b0);
        run_send(4'b1000, 1, 1'b0, N);

        // Back-to-back frames, in_valid held high with random in_bit while busy
        load_frame(4'b0001, 1'b1);
        run_send(4'b0001, 0, 1'b1, N);
        load_frame(4'b1111, 1'b1);
        run_send(4'b1111, 0, 1'b1, N);
        in_valid = 1'b0;

        // Reset during SEND after 3 bits
        load_frame(4'b0001, 1'b0);
        run_send(4'b0001, 0, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_out_bit", 32'(out_bit), 32'd0);
        chk("async_rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_frame(4'b0001, 1'b0);
        run_send(4'b0001, 0, 1'b0, N);

        // Reset during LOAD after 2 bits; new frame starts from bit 0
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_frame(4'b0100, 1'b0);
        run_send(4'b0100, 2, 1'b0, N);

        // Randomised frames
        for (int f = 0; f < 8; f++) begin
            info  = K'($urandom);
            mode  = int'($urandom_range(0, 2));
            noise = 1'($urandom);
            load_frame(info, noise);
            run_send(info, mode, noise, N);
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
